// File: rtl/arb_client_requester.sv
// Arbiter client: queues bus jobs in a small FIFO, requests the shared bus,
// streams each job's beats while granted, and resumes preempted jobs in place.
module arb_client_requester #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     job_push_i,
    input  logic [3:0]               job_len_i,
    output logic                     job_full_o,
    output logic [$clog2(DEPTH):0]   pend_cnt_o,
    output logic                     request_o,
    input  logic                     grant_i,
    output logic                     beat_valid_o,
    input  logic                     beat_ready_i,
    output logic                     beat_last_o,
    output logic                     done_o,
    output logic                     timeout_err_o
);

    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH) + 1;
    localparam int unsigned WaitW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StOwn,
        StRel,
        StBackoff
    } state_e;

    state_e            state_q, state_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    // An active job has been popped and still owes beats (set across preemption).
    logic              active_q, active_d;

    logic [3:0]        mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    logic              full;
    logic              pop;
    logic              push_ok;

    logic              request;
    logic              beat_valid;
    logic              beat_last;
    logic              done;
    logic              timeout_err;

    assign full    = (count_q == CntW'(DEPTH));
    // A pop frees a slot in the same cycle, so a push while full is still taken.
    assign push_ok = job_push_i && (!full || pop);

    // FSM next-state and outputs.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        beat_cnt_d  = beat_cnt_q;
        active_d    = active_q;
        pop         = 1'b0;
        request     = 1'b0;
        beat_valid  = 1'b0;
        beat_last   = 1'b0;
        done        = 1'b0;
        timeout_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if ((count_q != '0) || active_q) state_d = StReq;
            end
            StReq: begin
                request = 1'b1;
                if (grant_i) begin
                    state_d = StOwn;
                    wait_d  = '0;
                    if (!active_q) begin
                        pop        = 1'b1;
                        beat_cnt_d = mem_q[rd_ptr_q];
                        active_d   = 1'b1;
                    end
                end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
                    timeout_err = 1'b1;
                    state_d     = StBackoff;
                    wait_d      = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StOwn: begin
                request    = 1'b1;
                beat_valid = grant_i;
                beat_last  = grant_i && (beat_cnt_q == '0);
                if (!grant_i) begin
                    // Preempted: keep remaining beats, re-request without a pop.
                    state_d = StReq;
                end else if (beat_ready_i) begin
                    if (beat_cnt_q == '0) begin
                        state_d  = StRel;
                        active_d = 1'b0;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                    end
                end
            end
            StRel: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            StBackoff: begin
                state_d = StReq;
                wait_d  = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (push_ok && !pop)      count_d = count_q + 1'b1;
        else if (!push_ok && pop) count_d = count_q - 1'b1;
    end

    // State, counters and FIFO bookkeeping with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_q     <= '0;
            beat_cnt_q <= '0;
            active_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            beat_cnt_q <= beat_cnt_d;
            active_q   <= active_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful under the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= job_len_i;
    end

    assign job_full_o    = full;
    assign pend_cnt_o    = count_q;
    assign request_o     = request;
    assign beat_valid_o  = beat_valid;
    assign beat_last_o   = beat_last;
    assign done_o        = done;
    assign timeout_err_o = timeout_err;

endmodule

// File: doc/arb_client_requester.md
ARB_CLIENT_REQUESTER -- requirements
Module: arb_client_requester

Interface
REQ-001 Parameter DEPTH, default 4, job FIFO entries (power of two).
REQ-002 Parameter TIMEOUT, default 16, cycles in REQ without grant before timeout.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 job_push  in  1  enqueue one job when high and job_full low.
REQ-006 job_len  in  4  beats-1 of pushed job (0 = 1 beat, 15 = 16 beats).
REQ-007 job_full  out  1  FIFO holds DEPTH jobs.
REQ-008 pend_cnt  out  3  jobs in FIFO, excluding the active job.
REQ-009 request  out  1  request line to arbiter.
REQ-010 grant  in  1  grant line from arbiter, registered one cycle after request.
REQ-011 beat_valid  out  1  data beat offered to downstream bus.
REQ-012 beat_ready  in  1  downstream accepts beat.
REQ-013 beat_last  out  1  current beat is final beat of job.
REQ-014 done  out  1  one-cycle pulse after final beat accepted.
REQ-015 timeout_err  out  1  one-cycle pulse on request timeout.

Function
REQ-016 FSM states: IDLE, REQ, OWN, REL, BACKOFF; encoding is free.
REQ-017 IDLE: request=0; go to REQ when FIFO non-empty, or when a preempted job has beats remaining.
REQ-018 REQ: request=1; wait counter increments each cycle with grant=0.
REQ-019 REQ with grant=1: go to OWN; clear wait counter; for a new job, pop FIFO head and load beat counter with job_len.
REQ-020 REQ, wait counter reaching TIMEOUT-1 with grant=0: pulse timeout_err, go to BACKOFF; job stays in FIFO (or stays active if preempted).
REQ-021 BACKOFF: request=0 for exactly 1 cycle, then REQ; wait counter cleared.
REQ-022 OWN: request=1; beat_valid = grant; beat_last = beat_valid and beat counter==0.
REQ-023 Beat transfer = beat_valid and beat_ready; beat counter decrements per transfer.
REQ-024 Transfer with beat_last: go to REL.
REQ-025 REL: request=0, beat_valid=0, done=1 for exactly 1 cycle, then IDLE.
REQ-026 OWN with grant=0 (preemption): no transfer that cycle; go to REQ; remaining beat count kept; job resumes without a new pop.
REQ-027 Minimum latency: push in IDLE -> request high 2 cycles later (cycle 1 FIFO write, cycle 2 FSM leaves IDLE); first beat_valid 1 cycle after grant seen.
REQ-028 Push when job_full=1 is ignored; FIFO content unchanged.
REQ-029 Simultaneous push and pop: both occur; pend_cnt unchanged; legal when full.
REQ-030 FIFO pointers wrap modulo DEPTH; order strictly FIFO.
REQ-031 grant=1 while request=0 (IDLE, REL, BACKOFF) is ignored.
REQ-032 done and timeout_err are never high in the same cycle.

Reset
REQ-033 rst high: state IDLE; FIFO empty; counters 0; request, beat_valid, beat_last, done, timeout_err = 0; job_full = 0; pend_cnt = 0.
REQ-034 rst asserted mid-job aborts the job and discards all queued jobs; no done pulse.
REQ-035 After rst release, the first push is accepted in the first clock cycle.

Verification
REQ-036 Push len=2; grant 1 cycle after request; beat_ready=1 -> 3 beats, beat_last on 3rd, done 1 cycle later, request low in REL.
REQ-037 Push 5 jobs, DEPTH=4, no grant -> job_full=1 after 4th; 5th dropped; pend_cnt=4.
REQ-038 Request held, grant=0 for 16 cycles -> timeout_err pulse at cycle 16; request low 1 cycle; request re-asserted; pend_cnt unchanged.
REQ-039 Job len=7; drop grant after 3 beats for 2 cycles, then regrant -> total 8 beats, no duplicate/lost beats, single done.
REQ-040 beat_ready toggling 1/0 on len=3 -> 4 transfers only on ready cycles; beat_last held until accepted.
REQ-041 rst pulse mid-OWN with 2 jobs queued -> all outputs 0 asynchronously; pend_cnt=0; no done.
